// File: rtl/booth_pkg.sv
// Shared types and sizing helpers for the radix-4 Booth sequential multiplier.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package booth_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_CALC   = 2'd1,
        ST_FINISH = 2'd2
    } state_t;

    // One Booth digit in {0, +1, +2, -1, -2}: magnitude is a (or 2a if dbl), negated if neg.
    typedef struct packed {
        logic zero;
        logic neg;
        logic dbl;
    } digit_t;

    // Extended multiplier width: W+1 rounded up to an even number of bits, so the
    // top digit always sees the sign (or a zero pad bit in unsigned mode).
    function automatic int booth_e(input int w);
        int e;
        e = w + 1;
        if ((e % 2) != 0) begin
            e = e + 1;
        end
        return e;
    endfunction

    // Number of two-bit retire steps.
    function automatic int booth_iter(input int w);
        return booth_e(w) / 2;
    endfunction

endpackage

// File: rtl/booth_r4_recode.sv
// Radix-4 Booth recoder: multiplier triplet {b[2i+1], b[2i], b[2i-1]} to a digit.
// Latency: combinational.
// Backpressure: none.
module booth_r4_recode
    import booth_pkg::*;
(
    input  logic [2:0] trip,
    output digit_t     dig
);

    // Standard Booth table; 000 and 111 both mean "add nothing".
    always_comb begin
        dig = '0;
        case (trip)
            3'b000, 3'b111: dig.zero = 1'b1;
            3'b001, 3'b010: dig      = '0;
            3'b011:         dig.dbl  = 1'b1;
            3'b100: begin
                dig.neg = 1'b1;
                dig.dbl = 1'b1;
            end
            3'b101, 3'b110: dig.neg  = 1'b1;
            default:        dig      = '0;
        endcase
    end

endmodule

// File: rtl/booth_r4_seq_mult.sv
// Iterative radix-4 Booth multiplier (signed/unsigned) with pass-through tag.
// Latency: done in the cycle after edge ITER+1 from accept (edge 1 if an operand is zero).
// Backpressure: ready low while busy; start is ignored unless ready is high.
module booth_r4_seq_mult
    import booth_pkg::*;
#(
    parameter int W     = 24,
    parameter int TAG_W = 10
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               is_signed,
    input  logic [W-1:0]       a,
    input  logic [W-1:0]       b,
    input  logic [TAG_W-1:0]   tag_in,
    output logic               ready,
    output logic               done,
    output logic [2*W-1:0]     product,
    output logic [TAG_W-1:0]   tag_out
);

    localparam int E     = booth_e(W);
    localparam int ITER  = booth_iter(W);
    // Upper half carries E+2 bits: enough for the running sum plus +-2a without overflow.
    localparam int HI_W  = E + 2;
    // Accumulator layout: {hi[HI_W-1:0], b_ext[E-1:0], implicit 0}.
    localparam int ACC_W = HI_W + E + 1;
    localparam int CNT_W = $clog2(ITER) + 1;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [E:0]         a_q, a_d;
    logic [TAG_W-1:0]   tag_q, tag_d;
    logic               ready_q, ready_d;
    logic               done_q, done_d;
    logic [2*W-1:0]     product_q, product_d;
    logic [TAG_W-1:0]   tag_out_q, tag_out_d;

    logic [E:0]         a_ext;
    logic [E-1:0]       b_ext;
    logic               zero_op;
    digit_t             dig;
    logic [HI_W-1:0]    a_wide;
    logic [HI_W-1:0]    addend_mag;
    logic [HI_W-1:0]    addend;
    logic [HI_W-1:0]    hi_sum;
    logic [ACC_W-1:0]   acc_added;
    logic [ACC_W-1:0]   acc_step;

    // Operand extension at capture: sign or zero fill depending on mode.
    always_comb begin
        a_ext   = is_signed ? {{(E+1-W){a[W-1]}}, a} : {{(E+1-W){1'b0}}, a};
        b_ext   = is_signed ? {{(E-W){b[W-1]}}, b}   : {{(E-W){1'b0}}, b};
        zero_op = (a == '0) || (b == '0);
    end

    // The lowest accumulator triplet is always the one being retired.
    booth_r4_recode u_recode (
        .trip (acc_q[2:0]),
        .dig  (dig)
    );

    // One Booth step: add digit*a into the upper half, then arithmetic shift right by 2.
    always_comb begin
        a_wide     = {a_q[E], a_q};
        addend_mag = dig.dbl ? (a_wide << 1) : a_wide;
        addend     = dig.zero ? '0 : (dig.neg ? (~addend_mag + 1'b1) : addend_mag);
        hi_sum     = acc_q[ACC_W-1:E+1] + addend;
        acc_added  = {hi_sum, acc_q[E:0]};
        acc_step   = $signed(acc_added) >>> 2;
    end

    // FSM next-state and datapath updates.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        a_d       = a_q;
        tag_d     = tag_q;
        ready_d   = ready_q;
        done_d    = 1'b0;
        product_d = product_q;
        tag_out_d = tag_out_q;
        case (state_q)
            ST_IDLE: begin
                if (start && ready_q) begin
                    a_d     = a_ext;
                    tag_d   = tag_in;
                    cnt_d   = '0;
                    ready_d = 1'b0;
                    if (zero_op) begin
                        // Clearing the whole accumulator makes FINISH emit 0 directly.
                        acc_d   = '0;
                        state_d = ST_FINISH;
                    end else begin
                        acc_d   = {{HI_W{1'b0}}, b_ext, 1'b0};
                        state_d = ST_CALC;
                    end
                end
            end
            ST_CALC: begin
                acc_d = acc_step;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(ITER - 1)) begin
                    state_d = ST_FINISH;
                end
            end
            ST_FINISH: begin
                // Product LSB lands at accumulator bit 1 after E bits of shifting.
                product_d = acc_q[2*W:1];
                tag_out_d = tag_q;
                done_d    = 1'b1;
                ready_d   = 1'b1;
                state_d   = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                ready_d = 1'b1;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            acc_q     <= '0;
            a_q       <= '0;
            tag_q     <= '0;
            ready_q   <= 1'b1;
            done_q    <= 1'b0;
            product_q <= '0;
            tag_out_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            a_q       <= a_d;
            tag_q     <= tag_d;
            ready_q   <= ready_d;
            done_q    <= done_d;
            product_q <= product_d;
            tag_out_q <= tag_out_d;
        end
    end

    assign ready   = ready_q;
    assign done    = done_q;
    assign product = product_q;
    assign tag_out = tag_out_q;

endmodule

// File: doc/booth_r4_seq_mult.md
# booth_r4_seq_mult

Iterative radix-4 Booth multiplier with a parametrised operand width, selectable signed or unsigned mode, a start/ready/done handshake and a pass-through tag. It retires two multiplier bits per clock and supersedes the one-bit-per-stage Booth pipeline for mantissa products. Its main use is in the floating-point multiply path: the tag carries exponent and sign alongside the 2W-bit product.

## Interface
- W, 24, operand width in bits; legal range 4..64.
- TAG_W, 10, width of the side-band tag (exponent + sign), captured at start and returned with the result.
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset. There is one clock; reset is synchronous and active-high.
- start  in  1  request; sampled only while ready=1.
- is_signed  in  1  1 = both operands are two's complement; 0 = both unsigned. Captured with start.
- a  in  W  multiplicand.
- b  in  W  multiplier.
- tag_in  in  TAG_W  side-band data, captured with start.
- ready  out  1  high in IDLE; a start is accepted on any edge where start & ready.
- done  out  1  one-cycle pulse; product and tag_out are valid in that cycle and are held until the next done.
- product  out  2W  a*b, exact, in the selected signedness.
- tag_out  out  TAG_W  tag captured with the operation that produced product.

## Operation
- E = W+1 rounded up to even (W=24 gives E=26). ITER = E/2 (W=24 gives 13).
- Capture:
  - b is extended to E bits (sign-extended if is_signed, else zero-extended), with an implicit 0 appended below the LSB.
  - a is extended to E+1 bits the same way, so that ±2a fits.
- Each step:
  - Recode triplet {b[2i+1], b[2i], b[2i-1]} into a digit in {0, +1, +2, -1, -2}.
  - Add digit*a to the upper accumulator half.
  - Arithmetic-shift the accumulator right by 2.
- Final product = low 2W bits of the accumulator. This is exact for every operand pair in both modes.
- Zero shortcut: if a==0 or b==0 at capture, skip CALC and produce product=0.
- FSM states and transitions:
  - IDLE: start & ready → CALC, or → FINISH if the zero shortcut applies.
  - CALC: counter counts ITER steps; after the last step → FINISH.
  - FINISH: register product and tag_out, pulse done → IDLE.
- start while ready=0 is ignored entirely: no capture, and the in-flight operation is unaffected.
- Reset values: ready=1, done=0, product=0, tag_out=0, state IDLE, counter 0.
- Reset asserted mid-operation aborts it. No done is produced and product keeps its reset value 0.

## Timing
- Accepting edge is edge 0. Steps execute on edges 1..ITER. FINISH occurs on edge ITER+1.
- done is high only in the cycle after edge ITER+1; W=24 gives edge 14.
- Zero shortcut: done is high in the cycle after edge 1.
- ready falls after edge 0 and rises after the FINISH edge, in the same cycle as done.
- A start in the done cycle is accepted, giving back-to-back throughput of one result per ITER+2 cycles.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Structure
- Package booth_pkg holds:
  - the state enum (IDLE, CALC, FINISH);
  - the constant function computing E and ITER from W;
  - the digit encoding (zero, neg, dbl flags).
- Sub-module booth_r4_recode (combinational): 3-bit triplet → {zero, neg, dbl}. It is instantiated once and reused in every step.
- Top level contains the FSM, step counter, accumulator and the a/tag capture registers.

## Test plan
- W=24, signed, a=-3 (24'hFFFFFD), b=5 → after edge 14, done=1, product=48'hFFFF_FFFF_FFF1.
- W=24, unsigned, a=b=24'hFFFFFF → product=48'hFFFF_FE00_0001. The same operands in signed mode → product=48'h0000_0000_0001.
- W=24, signed, a=b=24'h800000 (most negative) → product=48'h4000_0000_0000; tag_in=10'h2A5 returns as tag_out=10'h2A5.
- Zero shortcut: a=0, b=24'h123456 → done after edge 1, product=0. Then a back-to-back start of 7*9 in the done cycle → product=63, 14 edges later.
- Start pulsed on edge 5 of a busy 2*3 with different operands and tag → result is still 6 with the original tag, and exactly one done.
- Reset asserted on edge 7 of an operation → the next cycle shows ready=1, done=0, product=0, and done never pulses for the aborted operation. A W=7 run (E=8, ITER=4) of -64 * -64 signed → product=14'h1000 after edge 5.
